// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the ARM pipeline stage registers: per-stage payload
// widths, ID/EX field offsets used when packing the payload, and the
// skid-stage state encoding (the state value doubles as the occupancy).
package arm_pipe_pkg;

  // Payload widths per pipeline boundary
  localparam int IF_ID_W  = 64;   // PC + instruction
  localparam int ID_EX_W  = 155;  // 7 ctrl + 4x4 fields + 3x32 + 12 shift + 24 imm
  localparam int EX_MEM_W = 71;   // 3 ctrl + ALU result + Rm value + dest
  localparam int MEM_WB_W = 70;   // 2 ctrl + ALU result + mem data + dest

  // ID/EX field offsets (LSB position of each field)
  localparam int IDEX_IMM24_LSB  = 0;
  localparam int IDEX_SHIFT_LSB  = 24;
  localparam int IDEX_RM_VAL_LSB = 36;
  localparam int IDEX_RN_VAL_LSB = 68;
  localparam int IDEX_PC_LSB     = 100;
  localparam int IDEX_DEST_LSB   = 132;
  localparam int IDEX_RM_LSB     = 136;
  localparam int IDEX_RN_LSB     = 140;
  localparam int IDEX_OPC_LSB    = 144;
  localparam int IDEX_CTRL_LSB   = 148;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// pipe_slot: WIDTH-bit payload register with load enable and synchronous
// clear. Clear wins over load; both clear and reset load FLUSH_VAL (a bubble).
module pipe_slot
  import arm_pipe_pkg::*;
#(
  parameter int               WIDTH     = ID_EX_W,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d, data_q;

  // Next payload: clear to bubble, else load, else hold
  always_comb begin
    data_d = data_q;
    if (clr)     data_d = FLUSH_VAL;
    else if (en) data_d = d;
  end

  // Payload storage, async reset to bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= FLUSH_VAL;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline stage with a 2-entry skid
// (main + skid), flush (kill all) and freeze (hold all) controls.
// in_ready depends only on state and freeze, so ready never combinationally
// follows out_ready; the skid entry absorbs the one extra beat this allows.
// Optional build macro: PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_skid_reg
  import arm_pipe_pkg::*;
#(
  parameter int               WIDTH     = ID_EX_W,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_bad
    $error("CNT_W must be at least 1");
  end

  pipe_state_t      state_d, state_q;
  logic             acc, drn;
  logic             main_en, main_clr, skid_en, skid_clr;
  logic [WIDTH-1:0] main_din, main_q, skid_q;

  assign in_ready  = (state_q != ST_SKID)  && !freeze;
  assign out_valid = (state_q != ST_EMPTY) && !freeze;
  assign acc       = in_valid  && in_ready;
  assign drn       = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;

  // Next state and slot controls; flush beats freeze, freeze blocks acc/drn
  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    main_clr = 1'b0;
    main_din = in_data;
    skid_en  = 1'b0;
    skid_clr = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!freeze) begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_en = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (acc && drn) begin
            main_en = 1'b1;
          end else if (acc) begin
            skid_en = 1'b1;
            state_d = ST_SKID;
          end else if (drn) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drn) begin
            main_en  = 1'b1;
            main_din = skid_q;
            skid_clr = 1'b1;
            state_d  = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  pipe_slot #(.WIDTH(WIDTH), .FLUSH_VAL(FLUSH_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .clr (main_clr),
    .d   (main_din),
    .q   (main_q)
  );

  pipe_slot #(.WIDTH(WIDTH), .FLUSH_VAL(FLUSH_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (skid_clr),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Saturating perf counters: stalled presents, and flushes that killed data
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a FIFO-queue model of the stage checked
// against the DUT every falling edge, directed scenarios with literal
// expectations, then randomized traffic.
module tb_pipe_stage_skid_reg;

  localparam int W  = 40;
  localparam int CW = 4;
  localparam logic [W-1:0] FV = 40'hF1_5500_0BAD;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0, freeze = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_skid_reg #(.WIDTH(W), .FLUSH_VAL(FV), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // model: queue of held payloads (head = presented), last main value, counters
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_main;
  int           m_stall, m_flush;
  logic [W-1:0] out_log[$];
  localparam int SAT = (1 << CW) - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_main  = FV;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare DUT against model, then advance the model by the coming edge
  always @(negedge clk) begin
    if (chk_en) begin
      int  occ;
      bit  drn, acc;
      occ = m_q.size();
      chk("out_valid", out_valid, (occ != 0) && !freeze);
      chk("in_ready",  in_ready,  (occ < 2)  && !freeze);
      chk("occupancy", occupancy, occ);
      chk("out_data",  out_data,  (occ != 0) ? m_q[0] : m_main);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`endif
      if (out_valid && out_ready) out_log.push_back(out_data);
      drn = (occ > 0) && !freeze && out_ready;
      acc = (occ < 2) && !freeze && in_valid;
      if ((occ > 0) && !freeze && !out_ready && m_stall < SAT) m_stall++;
      if (flush) begin
        if (occ > 0 && m_flush < SAT) m_flush++;
        m_q.delete();
        m_main = FV;
      end else begin
        if (drn) begin
          m_main = m_q[0];
          void'(m_q.pop_front());
        end
        if (acc) m_q.push_back(in_data);
        if (m_q.size() > 0) m_main = m_q[0];
      end
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    {flush, freeze, in_valid, out_ready} = '0;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_out_data",  out_data,  FV);
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  initial begin
    do_reset();

    // 1: stream 1..8 with out_ready high
    out_log.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      chk("t1_occ_le1", occupancy <= 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t1_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++)
      chk("t1_order", out_log[i], W'(i + 1));

    // 2: back-pressure fills the skid
    out_log.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'hA; tick();
    in_data = 40'hB; tick();
    in_valid = 1'b0;
    chk("t2_occ", occupancy, 2'd2);
    chk("t2_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("t2_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t2_first",  out_log[0], 40'hA);
      chk("t2_second", out_log[1], 40'hB);
    end

    // 3: flush from SKID drops same-cycle input
    out_log.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h11; tick();
    in_data = 40'h12; tick();
    in_data = 40'hC; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_occ", occupancy, 2'd0);
    chk("t3_out_valid", out_valid, 1'b0);
    chk("t3_out_data", out_data, FV);
    out_ready = 1'b1;
    tick();
    tick();
    chk("t3_nothing_out", out_log.size(), 0);

    // 4: freeze holds a FULL stage
    out_log.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'hD; tick();
    in_valid = 1'b0;
    freeze = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_frz_out_valid", out_valid, 1'b0);
      chk("t4_frz_in_ready", in_ready, 1'b0);
      tick();
    end
    freeze = 1'b0;
    #1;
    chk("t4_out_valid", out_valid, 1'b1);
    chk("t4_out_data", out_data, 40'hD);
    tick();
    chk("t4_drained", out_log.size(), 1);

    // 5: async reset mid-cycle while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h5A; tick();
    in_valid = 1'b0;
    chk("t5_pre_valid", out_valid, 1'b1);
    #1;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_occ", occupancy, 2'd0);
    chk("t5_out_data", out_data, FV);
    tick();
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    // 6: perf counters
    do_reset();
    in_valid = 1'b1; in_data = 40'h61; out_ready = 1'b0; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    in_valid = 1'b1; in_data = 40'h62; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("t6_stall5", stall_cnt, 4'd5);
    chk("t6_flush2", flush_cnt, 4'd2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 40'h63; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_stall_sat", stall_cnt, 4'hF);
    out_ready = 1'b1; tick();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < 65);
      flush     = ($urandom_range(99) < 3);
      freeze    = ($urandom_range(99) < 8);
      in_data   = {8'($urandom), $urandom};
      tick();
    end
    {flush, freeze, in_valid} = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
